// File: rtl/uart_pkg.sv
// Shared UART receiver definitions: frame defaults, clock/baud constants and the
// receive state encoding.
package uart_pkg;

    localparam int unsigned DATA_BITS_DEF  = 8;
    localparam int unsigned OVERSAMPLE_DEF = 16;
    localparam int unsigned CLK_HZ         = 100_000_000;
    localparam int unsigned BAUD_HZ        = 9600;
    localparam int unsigned TICK_HZ        = BAUD_HZ * OVERSAMPLE_DEF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_e;

    // Counter width for a modulo-n counter, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-facing signal bundle: baud level and serial line in, decoded byte and
// status pulses out.
interface uart_rx_if import uart_pkg::*; #(
    parameter int unsigned DATA_BITS = DATA_BITS_DEF
);

    logic                 baud;
    logic                 rx;
    logic [DATA_BITS-1:0] data_out;
    logic                 data_valid;
    logic                 frame_err;
    logic                 busy;

    modport master (
        output baud, rx,
        input  data_out, data_valid, frame_err, busy
    );

    modport slave (
        input  baud, rx,
        output data_out, data_valid, frame_err, busy
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit with a configurable
// reset value.
module sync_2ff import uart_pkg::*; #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start-bit qualification at mid-bit, LSB-first data
// capture, stop-bit check with one-clock valid / framing-error pulses.
module uart_rx import uart_pkg::*; #(
    parameter int unsigned DATA_BITS  = DATA_BITS_DEF,
    parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic       clk,
    input  logic       reset,
    uart_rx_if.slave   bus
);

    localparam int unsigned TW = cnt_width(OVERSAMPLE);
    localparam int unsigned BW = cnt_width(DATA_BITS);

    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    rx_state_e            state_q, state_d;
    logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 armed_q, armed_d;
    logic                 baud_q;
    logic                 rx_s;
    logic                 tick;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (bus.rx),
        .q_o   (rx_s)
    );

    assign tick = bus.baud & ~baud_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
            armed_q    <= 1'b0;
            baud_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
            armed_q    <= armed_d;
            baud_q     <= bus.baud;
        end
    end

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        ferr_d     = 1'b0;
        armed_d    = armed_q;

        if (tick) begin
            // A high line re-arms start detection; only a framing error disarms it.
            if (rx_s) begin
                armed_d = 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (!rx_s && armed_q) begin
                        state_d    = ST_START;
                        tick_cnt_d = '0;
                    end
                end

                ST_START: begin
                    if (tick_cnt_q == TICK_MID) begin
                        tick_cnt_d = '0;
                        if (!rx_s) begin
                            state_d   = ST_DATA;
                            bit_cnt_d = '0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end

                ST_DATA: begin
                    if (tick_cnt_q == TICK_LAST) begin
                        shift_d    = {rx_s, shift_q[DATA_BITS-1:1]};
                        tick_cnt_d = '0;
                        if (bit_cnt_q == BIT_LAST) begin
                            state_d = ST_STOP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end

                ST_STOP: begin
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d = '0;
                        state_d    = ST_IDLE;
                        if (rx_s) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            ferr_d  = 1'b1;
                            armed_d = 1'b0;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign bus.data_out   = data_q;
    assign bus.data_valid = valid_q;
    assign bus.frame_err  = ferr_q;
    assign bus.busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frame table, multi-cycle corner
// sequences and randomized frames against a frame-level reference model.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int unsigned OS       = 16;
    localparam int unsigned DB       = 8;
    localparam int unsigned BAUD_PER = 6;
    // Line change -> detect (1 tick, synchronizer) -> mid start (OS/2) -> 9 samples.
    localparam int unsigned STOP_TICK = 1 + OS / 2 + OS * (DB + 1);

    logic clk = 1'b0;
    logic reset;

    uart_rx_if #(.DATA_BITS(DB)) bus ();

    uart_rx #(
        .DATA_BITS  (DB),
        .OVERSAMPLE (OS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int unsigned tests    = 0;
    int unsigned failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Oversample level generator; holds its level while paused.
    bit          baud_run  = 1'b1;
    int unsigned tick_no   = 0;
    longint      rise_time = 0;
    int unsigned bcnt      = 0;

    initial begin
        bus.baud = 1'b0;
        forever begin
            @(negedge clk);
            if (baud_run) begin
                bcnt = (bcnt + 1) % BAUD_PER;
                if (bcnt == 0) begin
                    tick_no++;
                    rise_time = $time;
                    bus.baud  = 1'b1;
                end else if (bcnt == BAUD_PER / 2) begin
                    bus.baud = 1'b0;
                end
            end
        end
    end

    typedef struct {
        bit          is_err;
        logic [7:0]  dout;
        int unsigned tick;
        longint      dt;
    } ev_t;

    ev_t got[$];
    bit  dv_prev = 1'b0;
    bit  fe_prev = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!reset && (bus.data_valid || bus.frame_err)) begin
                check("valid_ferr_exclusive", 64'(bus.data_valid & bus.frame_err), 0);
                check("pulse_width", 64'((bus.data_valid & dv_prev) | (bus.frame_err & fe_prev)), 0);
                got.push_back('{is_err: bus.frame_err, dout: bus.data_out,
                                tick: tick_no, dt: $time - rise_time});
            end
            dv_prev = bus.data_valid;
            fe_prev = bus.frame_err;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int unsigned start_tick;

    task automatic wait_ticks(input int unsigned n);
        repeat (n) @(posedge bus.baud);
    endtask

    task automatic idle(input int unsigned n);
        bus.rx = 1'b1;
        wait_ticks(n);
    endtask

    task automatic pause_baud();
        baud_run = 1'b0;
        repeat (4) begin
            repeat (500) @(negedge clk);
            check("pause_busy", 64'(bus.busy), 1);
            check("pause_no_event", 64'(got.size()), 0);
        end
        baud_run = 1'b1;
    endtask

    // Called right after a baud rise; returns right after the rise ending the stop bit.
    task automatic send_frame(input logic [7:0] d, input bit stop, input int pause_bit);
        start_tick = tick_no;
        bus.rx = 1'b0;
        wait_ticks(OS);
        for (int i = 0; i < 8; i++) begin
            bus.rx = d[i];
            if (i == pause_bit) begin
                wait_ticks(OS / 2);
                pause_baud();
                wait_ticks(OS / 2);
            end else begin
                wait_ticks(OS);
            end
        end
        bus.rx = stop;
        wait_ticks(OS);
    endtask

    task automatic check_event(input bit exp_err, input logic [7:0] exp_dout);
        ev_t e;
        if (got.size() == 0) begin
            check("event_present", 0, 1);
        end else begin
            e = got.pop_front();
            check("event_kind_err", 64'(e.is_err), 64'(exp_err));
            check("data_out", 64'(e.dout), 64'(exp_dout));
            check("latency_ticks", 64'(e.tick - start_tick), 64'(STOP_TICK));
            check("latency_clk", 64'(e.dt), 6);
            check("extra_events", 64'(got.size()), 0);
        end
    endtask

    typedef struct {
        logic [7:0]  data;
        bit          stop;
        int unsigned gap;
        bit          exp_err;
        logic [7:0]  exp_dout;
    } vec_t;

    vec_t       vecs[7];
    logic [7:0] model_last;
    logic [7:0] rd;
    bit         rstop;
    logic [7:0] partial;

    initial begin
        vecs[0] = '{8'h55, 1'b1, 4,  1'b0, 8'h55};
        vecs[1] = '{8'hA3, 1'b1, 0,  1'b0, 8'hA3};
        vecs[2] = '{8'h0F, 1'b1, 8,  1'b0, 8'h0F};
        vecs[3] = '{8'h00, 1'b1, 0,  1'b0, 8'h00};
        vecs[4] = '{8'hFF, 1'b1, 0,  1'b0, 8'hFF};
        vecs[5] = '{8'h81, 1'b0, 20, 1'b1, 8'hFF};
        vecs[6] = '{8'h7E, 1'b1, 2,  1'b0, 8'h7E};

        reset  = 1'b1;
        bus.rx = 1'b1;
        repeat (4) @(negedge clk);
        check("reset_data_out", 64'(bus.data_out), 0);
        check("reset_data_valid", 64'(bus.data_valid), 0);
        check("reset_frame_err", 64'(bus.frame_err), 0);
        check("reset_busy", 64'(bus.busy), 0);
        reset = 1'b0;
        @(posedge bus.baud);
        idle(4);

        for (int i = 0; i < 7; i++) begin
            send_frame(vecs[i].data, vecs[i].stop, -1);
            check_event(vecs[i].exp_err, vecs[i].exp_dout);
            idle(vecs[i].gap);
        end

        // Short low glitch must be rejected at the start-bit midpoint.
        bus.rx = 1'b0;
        wait_ticks(2);
        check("glitch_busy_high", 64'(bus.busy), 1);
        wait_ticks(2);
        bus.rx = 1'b1;
        wait_ticks(8);
        check("glitch_busy_dropped", 64'(bus.busy), 0);
        check("glitch_no_event", 64'(got.size()), 0);
        idle(8);

        // Framing error followed by a held-low break: no restart until the line rises.
        send_frame(8'hFF, 1'b0, -1);
        check_event(1'b1, 8'h7E);
        wait_ticks(16);
        check("break_busy_a", 64'(bus.busy), 0);
        wait_ticks(16);
        check("break_busy_b", 64'(bus.busy), 0);
        check("break_no_event", 64'(got.size()), 0);
        idle(16);
        send_frame(8'h5A, 1'b1, -1);
        check_event(1'b0, 8'h5A);
        idle(4);

        // Reset in the middle of data bit 3.
        partial = 8'h96;
        bus.rx = 1'b0;
        wait_ticks(OS);
        for (int i = 0; i < 3; i++) begin
            bus.rx = partial[i];
            wait_ticks(OS);
        end
        bus.rx = partial[3];
        wait_ticks(OS / 2);
        check("pre_reset_busy", 64'(bus.busy), 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midreset_data_out", 64'(bus.data_out), 0);
        check("midreset_data_valid", 64'(bus.data_valid), 0);
        check("midreset_frame_err", 64'(bus.frame_err), 0);
        check("midreset_busy", 64'(bus.busy), 0);
        @(negedge clk);
        reset  = 1'b0;
        bus.rx = 1'b1;
        @(posedge bus.baud);
        idle(40);
        check("post_reset_no_event", 64'(got.size()), 0);
        send_frame(8'h3C, 1'b1, -1);
        check_event(1'b0, 8'h3C);
        idle(3);

        // Baud held constant mid-frame (scaled stand-in for a long stall).
        send_frame(8'hC6, 1'b1, 4);
        check_event(1'b0, 8'hC6);
        idle(2);

        model_last = 8'hC6;
        for (int i = 0; i < 24; i++) begin
            rd    = 8'($urandom_range(0, 255));
            rstop = ($urandom_range(0, 5) != 0);
            send_frame(rd, rstop, -1);
            check_event(!rstop, rstop ? rd : model_last);
            if (rstop) begin
                model_last = rd;
                idle($urandom_range(0, 3));
            end else begin
                idle(16 + $urandom_range(0, 8));
            end
        end
        idle(4);
        check("final_busy", 64'(bus.busy), 0);
        check("final_no_event", 64'(got.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
